// File: rtl/pwm_output_ctrl.sv
// PWM output controller: drives 16 pins as off, static high, or a shared PWM waveform.
// The PWM duty is double-buffered and only takes effect at period boundaries, so a
// mid-period register write cannot produce a runt or stretched pulse.
module pwm_output_ctrl #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  // A width of one still works for PRESCALE=1: the counter stays at zero and ticks every cycle.
  localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);

  logic [PresW-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_shadow_q, duty_shadow_d;
  logic             load_pending_q;
  logic [15:0]      out_q, out_d;
  logic             period_start_q;

  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  // Prescaler, PWM counter, duty shadow and pin mux next-state logic.
  always_comb begin
    tick      = (presc_cnt_q == PresMax);
    wrap      = tick && (pwm_cnt_q == 8'hFF);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PresW'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // The post-reset load makes the first period use the requested duty instead of zero.
    duty_shadow_d = (wrap || load_pending_q) ? pwm_duty_cycle : duty_shadow_q;
    // 0xFF is special-cased so full scale is truly constant high, not 255/256.
    pwm_level = (duty_shadow_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_shadow_q);
    en_out    = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    out_d     = en_out & (~en_pwm | {16{pwm_level}});
  end

  // State update; reset overrides every other event and clears the pins immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q    <= '0;
      pwm_cnt_q      <= 8'h00;
      duty_shadow_q  <= 8'h00;
      load_pending_q <= 1'b1;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      load_pending_q <= 1'b0;
      out_q          <= out_d;
      period_start_q <= wrap;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule
